// File: rtl/stream_demux.sv
// Registered 1-to-NUM_ELEM valid/ready stream demultiplexer with per-packet
// route locking, one-entry output registers and a saturating drop counter.
module stream_demux #(
  parameter  int NUM_ELEM = 4,
  parameter  int DATA_W   = 8,
  parameter  int CNT_W    = 8,
  localparam int SEL_W    = $clog2(NUM_ELEM)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [SEL_W-1:0]           s_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_last_i,
  output logic [NUM_ELEM-1:0]        out_valid_o,
  input  logic [NUM_ELEM-1:0]        out_ready_i,
  output logic [NUM_ELEM*DATA_W-1:0] out_data_o,
  output logic [NUM_ELEM-1:0]        out_last_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t                     state_q, state_d;
  logic [SEL_W-1:0]           lock_q, lock_d;
  logic [SEL_W-1:0]           tgt;
  logic                       tgt_ok;
  logic                       tgt_busy;
  logic                       accept;
  logic                       drop;
  logic [NUM_ELEM-1:0]        fill;
  logic [(1<<SEL_W)-1:0]      sel_ok;
  logic [NUM_ELEM-1:0]        valid_q;
  logic [NUM_ELEM-1:0]        last_q;
  logic [NUM_ELEM*DATA_W-1:0] data_q;
  logic [CNT_W-1:0]           drop_cnt_q;

  // Table of in-range select codes; avoids comparing the select against a
  // constant that may exceed its range when NUM_ELEM is a power of two.
  always_comb begin
    sel_ok = '0;
    for (int unsigned i = 0; i < (1 << SEL_W); i++) begin
      sel_ok[i] = (i < NUM_ELEM);
    end
  end

  always_comb begin
    tgt      = (state_q == PKT) ? lock_q : s_i;
    tgt_ok   = (state_q != DROP) && sel_ok[tgt];
    tgt_busy = 1'b0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      if (tgt == SEL_W'(k)) tgt_busy = valid_q[k] & ~out_ready_i[k];
    end
    if (rst_i)       in_ready_o = 1'b0;
    else if (tgt_ok) in_ready_o = ~tgt_busy;
    else             in_ready_o = 1'b1;
    accept = in_valid_i & in_ready_o;
    drop   = accept & ~tgt_ok;
    fill   = '0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      fill[k] = accept & tgt_ok & (tgt == SEL_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last_i) begin
            if (tgt_ok) begin
              state_d = PKT;
              lock_d  = s_i;
            end else begin
              state_d = DROP;
            end
          end
        end
        PKT, DROP: if (in_last_i) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Fill takes priority so a same-cycle drain and refill keeps valid high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        if (fill[k]) begin
          valid_q[k]                <= 1'b1;
          last_q[k]                 <= in_last_i;
          data_q[k*DATA_W +: DATA_W] <= in_data_i;
        end else if (out_ready_i[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_data_o  = data_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered, handshaked 1-to-NUM_ELEM stream demultiplexer: the sequential successor of the team's combinational `demux`. It routes multi-bit data beats on a valid/ready input to one of NUM_ELEM valid/ready outputs, locks the route for the whole of a packet, and holds each output in its own one-entry register. Beats with an out-of-range select are dropped and counted. The block sits between a packet source and NUM_ELEM independent consumers.

## Interface
- NUM_ELEM, 4, number of output channels; must be at least 2 and need not be a power of two.
- DATA_W, 8, data beat width in bits; must be at least 1.
- SEL_W, derived as $clog2(NUM_ELEM); width of the select.
- CNT_W, 8, width of the drop counter.

- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- s_i  input  SEL_W  output channel select; sampled only on the first beat of a packet.
- in_valid_i  input  1  an input beat is present.
- in_ready_o  output  1  the block accepts the input beat this cycle.
- in_data_i  input  DATA_W  input beat data.
- in_last_i  input  1  this beat is the final beat of its packet.
- out_valid_o  output  NUM_ELEM  channel k holds a beat.
- out_ready_i  input  NUM_ELEM  consumer k takes the beat this cycle.
- out_data_o  output  NUM_ELEM*DATA_W  channel k data, at bits [k*DATA_W +: DATA_W].
- out_last_o  output  NUM_ELEM  channel k last flag.
- drop_cnt_o  output  CNT_W  saturating count of dropped beats.

## Operation
- An input beat is accepted when in_valid_i and in_ready_o are both 1.
- An output beat on channel k completes when out_valid_o[k] and out_ready_i[k] are both 1.
- **FSM states:**
  - IDLE: the next accepted beat is the first beat of a packet.
  - PKT: a packet is routed to the locked channel lock_q.
  - DROP: a packet is being discarded.
- **Target channel:**
  - In IDLE, the target is s_i.
  - In PKT, the target is lock_q; s_i is ignored.
  - In DROP, there is no target.
- **Ready:**
  - In IDLE with s_i < NUM_ELEM, and in PKT, in_ready_o = !out_valid_o[tgt] | out_ready_i[tgt].
  - In IDLE with s_i >= NUM_ELEM, and in DROP, in_ready_o = 1.
  - in_ready_o is combinational from out_ready_i, s_i and state.
- **Routed accept:** on the next edge, channel tgt register loads in_data_i and in_last_i, and out_valid_o[tgt] is set to 1.
- **Transitions on an accepted beat:**
  - IDLE, valid select, in_last_i = 0: go to PKT and set lock_q = s_i.
  - IDLE, valid select, in_last_i = 1: stay in IDLE.
  - IDLE, s_i >= NUM_ELEM: the beat is dropped and drop_cnt_o increments. Go to DROP if in_last_i = 0; otherwise stay in IDLE.
  - PKT, in_last_i = 1: return to IDLE.
  - DROP: every accepted beat increments drop_cnt_o; in_last_i = 1 returns to IDLE.
- drop_cnt_o saturates at 2^CNT_W-1 and does not wrap.
- **Per-channel register update:**
  - Drain without fill: out_valid_o[k] clears to 0.
  - Drain and fill in the same cycle: out_valid_o[k] stays 1 and the data and last flag are replaced.
  - Neither: the register holds.
- Channels are independent. A stalled channel never blocks beats already held in other channels.
- An out-of-range select can occur only when NUM_ELEM is not a power of two.

## Timing
- Latency is 1 cycle: a beat accepted on edge N is visible on out_*_o of its channel from edge N+1.
- Throughput: one beat per cycle sustained while the target consumer holds out_ready_i high.
- **Reset values:**
  - out_valid_o = 0, out_data_o = 0, out_last_o = 0, drop_cnt_o = 0.
  - State = IDLE, lock_q = 0.
  - While rst_i is high, in_ready_o = 0.
- **Reset mid-packet:**
  - All buffered beats are discarded and the FSM returns to IDLE.
  - The first beat after reset is treated as a packet head.
- out_valid_o[k], out_data_o and out_last_o for a held beat stay stable until that beat is drained.

## Test plan
- **Reset:** assert rst_i during PKT with channel 2 full -> on the next cycle all out_valid_o = 0, drop_cnt_o = 0, and in_ready_o = 0 while rst_i is high. The first beat after reset routes using s_i.
- **Packet lock:** NUM_ELEM=4. Send a 3-beat packet with s_i = 1 on the head beat, then s_i = 3, 0 on the following beats -> all beats (0xA1, 0xA2, 0xA3) appear on channel 1 only, with out_last_o[1] = 1 on 0xA3.
- **Backpressure and independence:** hold out_ready_i[0] = 0 and send beat 0x11 to channel 0, then a single-beat packet 0x22 to channel 2 -> 0x22 is delivered on channel 2. A further beat to channel 0 is stalled (in_ready_o = 0) until out_ready_i[0] = 1.
- **Full throughput:** send 16 single-beat packets back-to-back to channel 3 with out_ready_i[3] = 1 -> in_ready_o stays 1, one output per cycle, 1-cycle latency, and no beat lost or duplicated.
- **Drop and saturation:** NUM_ELEM=3, CNT_W=2. Send a 4-beat packet with s_i = 3 -> no out_valid_o asserts and drop_cnt_o reads 3, then stays 3 after two more dropped beats. Next, a head beat with s_i = 0 routes normally to channel 0.
- **Simultaneous drain and fill:** with channel 0 full of 0x55 and out_ready_i[0] = 1, accept 0x66 for channel 0 -> out_valid_o[0] stays 1 and out_data_o[7:0] = 0x66 on the next cycle.
